axi4lite_reg_slave: RTL and testbench
=====================================

# axi4lite_reg_slave

AXI4-Lite responder terminating the slave modport of `axi4lite_intf`, implementing a bank of `NUM_REGS` 32-bit read/write control registers. It sits at the end of the control-plane interconnect, facing a master such as a CPU bridge or debug host. It exposes register contents and per-register write pulses to fabric logic. One write and one read transaction may be outstanding at a time, and the two channels are fully independent.

## Interface
- `NUM_REGS`, 16: number of 32-bit registers, 1..256.
- `BASE_ADDR`, 32'h0000_0000: byte address of register 0; must be aligned to `NUM_REGS*4` rounded up to a power of two.
- `clk` input 1: sole clock. One clock; reset is synchronous and active-high.
- `rst` input 1: synchronous, active-high reset.
- `s_axi` interface `axi4lite_intf.slave`: AXI4-Lite slave port.
- `regs_o` output `NUM_REGS*32`: current register contents; register k occupies bits [32k+31:32k].
- `wr_pulse_o` output `NUM_REGS`: bit k is high for one cycle, the cycle after register k is committed.

## Operation
- Decode:
  - `offset = addr - BASE_ADDR`; `index = offset[9:2]`; `addr[1:0]` is ignored.
  - The access is in range iff `addr >= BASE_ADDR` and `index < NUM_REGS`.
  - `awprot` and `arprot` are ignored.
- Write path: two holding slots, AW and W, each with a valid flag.
  - `awready = !aw_held && !bvalid && !rst`.
  - `wready = !w_held && !bvalid && !rst`.
  - AW and W may handshake in either order or in the same cycle. Each captures into its slot on `valid && ready`.
  - Commit happens in the first cycle where both slots are held, or are being filled this cycle, and `bvalid` is low.
  - In range: each byte lane i with `wstrb[i]=1` updates `reg[index][8i+7:8i]`. `bresp = 2'b00`.
  - `wstrb = 4'b0000` in range: no data change, `bresp = 2'b00`, and the pulse still fires.
  - Out of range: no register changes, no pulse, `bresp = 2'b10` (SLVERR).
  - Commit clears both slots and sets `bvalid` on the next edge.
  - `bvalid` holds, with `bresp` stable, until `bready`. It clears on the edge where `bvalid && bready`.
- Read path:
  - `arready = !rvalid && !rst`.
  - On `arvalid && arready`, `rdata` and `rresp` are registered and `rvalid` rises on the next edge.
  - In range: `rdata = reg[index]`, `rresp = 2'b00`.
  - Out of range: `rdata = 32'h0`, `rresp = 2'b10`.
  - `rvalid`, `rdata` and `rresp` hold stable until `rready`. `rvalid` clears on the `rvalid && rready` edge.
- Simultaneous read and write to the same register in the same cycle: the read returns the pre-write value.
- The write and read channels never stall each other.

## Timing
- Reset (`rst` high at an edge):
  - All registers, `regs_o` and `wr_pulse_o` go to 0.
  - Slot flags clear.
  - `bvalid`, `rvalid`, `bresp`, `rresp` and `rdata` go to 0.
  - `awready`, `wready` and `arready` are forced low while `rst` is high.
- Reset mid-transaction discards any held AW/W, any pending B and any pending R response. Nothing is committed.
- Write latency: `bvalid` rises 1 cycle after the later of the AW and W handshakes. If AW and W arrive together, `bvalid` rises 1 cycle later.
- `regs_o` updates on the same edge that `bvalid` rises. `wr_pulse_o` is high during the first `bvalid` cycle.
- Read latency: `rvalid` rises 1 cycle after the AR handshake.
- Throughput:
  - One write per 2 cycles with `bready` tied high, because `awready` and `wready` are low while `bvalid` is high.
  - One read per 2 cycles with `rready` tied high.
- Backpressure: with `bready` low, no further AW/W is accepted. With `rready` low, no further AR is accepted.
- A second AW while AW is held and W is not yet received: `awready` is low, so the master holds the request.

## Test plan
- Reset, then AW (0x4) and W (0xDEADBEEF, strb 0xF) in the same cycle with bready=1 -> `bvalid` at +1 with bresp=00, `regs_o[63:32]=DEADBEEF`, `wr_pulse_o=16'h0002` for 1 cycle. Then AR 0x4 -> `rvalid` at +1 with rdata=DEADBEEF, rresp=00.
- W (0x11223344, strb 0x5) 3 cycles before AW 0x8, on reg2 previously 0xAABBCCDD -> only 1 `bvalid`, 1 cycle after AW; reg2=0xAA22CC44.
- AW 0x40 (index 16, NUM_REGS=16) with data 0xFFFFFFFF -> bresp=10, all registers unchanged, `wr_pulse_o=0`. AR 0x40 -> rdata=0, rresp=10.
- bready=0 for 5 cycles after a write, with a second AW/W presented -> `awready` and `wready` stay low and `bvalid`/`bresp` stay stable. Release bready -> second write completes 1 cycle after acceptance.
- Same cycle: AR and a committing write to reg3 (old 0x1, new 0x2) -> rdata=0x1, and a following read returns 0x2. Then assert `rst` for 1 cycle while `rvalid` is pending and AW is held -> `rvalid=0`, regs=0, and no `bvalid` ever appears.

Source files
------------

// File: rtl/axi4lite_reg_slave_if.sv
// AXI4-Lite bus bundle (32-bit address and data) shared by control-plane masters and register slaves.
// Clock and reset are carried as plain ports on the attached modules.
interface axi4lite_intf;
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned STRB_W = DATA_W / 8;

    logic              awvalid;
    logic              awready;
    logic [ADDR_W-1:0] awaddr;
    logic [2:0]        awprot;

    logic              wvalid;
    logic              wready;
    logic [DATA_W-1:0] wdata;
    logic [STRB_W-1:0] wstrb;

    logic              bvalid;
    logic              bready;
    logic [1:0]        bresp;

    logic              arvalid;
    logic              arready;
    logic [ADDR_W-1:0] araddr;
    logic [2:0]        arprot;

    logic              rvalid;
    logic              rready;
    logic [DATA_W-1:0] rdata;
    logic [1:0]        rresp;

    modport master (
        output awvalid, awaddr, awprot,
        input  awready,
        output wvalid, wdata, wstrb,
        input  wready,
        input  bvalid, bresp,
        output bready,
        output arvalid, araddr, arprot,
        input  arready,
        input  rvalid, rdata, rresp,
        output rready
    );

    modport slave (
        input  awvalid, awaddr, awprot,
        output awready,
        input  wvalid, wdata, wstrb,
        output wready,
        output bvalid, bresp,
        input  bready,
        input  arvalid, araddr, arprot,
        output arready,
        output rvalid, rdata, rresp,
        input  rready
    );
endinterface

// File: rtl/axi4lite_reg_slave.sv
// AXI4-Lite register bank: NUM_REGS 32-bit read/write registers with per-register write pulses.
// Write and read channels are independent; one transaction of each may be outstanding.
module axi4lite_reg_slave #(
    parameter int unsigned NUM_REGS  = 16,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic                     clk,
    input  logic                     rst,
    axi4lite_intf.slave              s_axi,
    output logic [NUM_REGS*32-1:0]   regs_o,
    output logic [NUM_REGS-1:0]      wr_pulse_o
);
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned STRB_W = DATA_W / 8;
    localparam int unsigned IDX_W  = 8;
    localparam logic [1:0]  RESP_OKAY   = 2'b00;
    localparam logic [1:0]  RESP_SLVERR = 2'b10;

    // Write holding slots
    logic              aw_held_q;
    logic              w_held_q;
    logic [ADDR_W-1:0] aw_addr_q;
    logic [DATA_W-1:0] w_data_q;
    logic [STRB_W-1:0] w_strb_q;

    // Response registers
    logic              bvalid_q;
    logic [1:0]        bresp_q;
    logic              rvalid_q;
    logic [1:0]        rresp_q;
    logic [DATA_W-1:0] rdata_q;

    // Handshake and decode terms
    logic              awready_c;
    logic              wready_c;
    logic              arready_c;
    logic              aw_fill_c;
    logic              w_fill_c;
    logic              ar_fill_c;
    logic              commit_c;
    logic [ADDR_W-1:0] wr_addr_c;
    logic [DATA_W-1:0] wr_data_c;
    logic [STRB_W-1:0] wr_strb_c;
    logic [ADDR_W:0]   wr_off_c;
    logic [IDX_W-1:0]  wr_idx_c;
    logic              wr_in_c;
    logic [ADDR_W:0]   rd_off_c;
    logic [IDX_W-1:0]  rd_idx_c;
    logic              rd_in_c;
    logic [DATA_W-1:0] rd_word_c;

    assign awready_c = !aw_held_q && !bvalid_q && !rst;
    assign wready_c  = !w_held_q  && !bvalid_q && !rst;
    assign arready_c = !rvalid_q && !rst;

    assign aw_fill_c = s_axi.awvalid && awready_c;
    assign w_fill_c  = s_axi.wvalid  && wready_c;
    assign ar_fill_c = s_axi.arvalid && arready_c;

    // Commit as soon as both halves are present, whether held or arriving now
    assign commit_c = (aw_held_q || aw_fill_c) && (w_held_q || w_fill_c) && !bvalid_q;

    assign wr_addr_c = aw_fill_c ? s_axi.awaddr : aw_addr_q;
    assign wr_data_c = w_fill_c  ? s_axi.wdata  : w_data_q;
    assign wr_strb_c = w_fill_c  ? s_axi.wstrb  : w_strb_q;

    // Bit ADDR_W of the widened difference is the borrow, i.e. addr < BASE_ADDR
    assign wr_off_c = {1'b0, wr_addr_c} - {1'b0, BASE_ADDR};
    assign wr_idx_c = wr_off_c[9:2];
    assign wr_in_c  = !wr_off_c[ADDR_W] && ({1'b0, wr_idx_c} < 9'(NUM_REGS));

    assign rd_off_c = {1'b0, s_axi.araddr} - {1'b0, BASE_ADDR};
    assign rd_idx_c = rd_off_c[9:2];
    assign rd_in_c  = !rd_off_c[ADDR_W] && ({1'b0, rd_idx_c} < 9'(NUM_REGS));

    // Read mux sees the pre-write contents, so a same-cycle read returns the old value
    always_comb begin
        rd_word_c = '0;
        for (int k = 0; k < int'(NUM_REGS); k++) begin
            if (rd_idx_c == IDX_W'(k)) begin
                rd_word_c = regs_o[32*k +: 32];
            end
        end
    end

    // Write slots and B channel
    always_ff @(posedge clk) begin
        if (rst) begin
            aw_held_q <= 1'b0;
            w_held_q  <= 1'b0;
            aw_addr_q <= '0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
        end else begin
            if (aw_fill_c) begin
                aw_addr_q <= s_axi.awaddr;
            end
            if (w_fill_c) begin
                w_data_q <= s_axi.wdata;
                w_strb_q <= s_axi.wstrb;
            end
            if (commit_c) begin
                aw_held_q <= 1'b0;
                w_held_q  <= 1'b0;
                bvalid_q  <= 1'b1;
                bresp_q   <= wr_in_c ? RESP_OKAY : RESP_SLVERR;
            end else begin
                if (aw_fill_c) begin
                    aw_held_q <= 1'b1;
                end
                if (w_fill_c) begin
                    w_held_q <= 1'b1;
                end
                if (bvalid_q && s_axi.bready) begin
                    bvalid_q <= 1'b0;
                end
            end
        end
    end

    // Register bank and write pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            regs_o     <= '0;
            wr_pulse_o <= '0;
        end else begin
            wr_pulse_o <= '0;
            for (int k = 0; k < int'(NUM_REGS); k++) begin
                if (commit_c && wr_in_c && (wr_idx_c == IDX_W'(k))) begin
                    wr_pulse_o[k] <= 1'b1;
                    for (int b = 0; b < int'(STRB_W); b++) begin
                        if (wr_strb_c[b]) begin
                            regs_o[32*k + 8*b +: 8] <= wr_data_c[8*b +: 8];
                        end
                    end
                end
            end
        end
    end

    // R channel
    always_ff @(posedge clk) begin
        if (rst) begin
            rvalid_q <= 1'b0;
            rresp_q  <= RESP_OKAY;
            rdata_q  <= '0;
        end else begin
            if (ar_fill_c) begin
                rvalid_q <= 1'b1;
                rresp_q  <= rd_in_c ? RESP_OKAY : RESP_SLVERR;
                rdata_q  <= rd_in_c ? rd_word_c : '0;
            end else if (rvalid_q && s_axi.rready) begin
                rvalid_q <= 1'b0;
            end
        end
    end

    assign s_axi.awready = awready_c;
    assign s_axi.wready  = wready_c;
    assign s_axi.arready = arready_c;
    assign s_axi.bvalid  = bvalid_q;
    assign s_axi.bresp   = bresp_q;
    assign s_axi.rvalid  = rvalid_q;
    assign s_axi.rresp   = rresp_q;
    assign s_axi.rdata   = rdata_q;

    // Protection bits and address bits outside the decode window carry no meaning here
    logic unused_ok;
    assign unused_ok = ^{s_axi.awprot, s_axi.arprot,
                         wr_off_c[ADDR_W-1:10], wr_off_c[1:0],
                         rd_off_c[ADDR_W-1:10], rd_off_c[1:0]};
endmodule

// File: tb/tb_axi4lite_reg_slave.sv
// Directed bench for axi4lite_reg_slave: reset, writes, strobes, decode errors, backpressure,
// same-cycle read/write ordering and reset in the middle of transactions.
module tb_axi4lite_reg_slave;
    localparam int unsigned NR = 16;

    logic clk;
    logic rst;
    logic [NR*32-1:0] regs_o;
    logic [NR-1:0]    wr_pulse_o;
    logic [NR*32-1:0] exp_regs;

    int tests;
    int fails;

    axi4lite_intf s_axi ();

    axi4lite_reg_slave #(.NUM_REGS(NR), .BASE_ADDR(32'h0000_0000)) dut (
        .clk        (clk),
        .rst        (rst),
        .s_axi      (s_axi),
        .regs_o     (regs_o),
        .wr_pulse_o (wr_pulse_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one edge and settle so the next samples are away from the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_bus();
        s_axi.awvalid = 1'b0; s_axi.awaddr = '0; s_axi.awprot = '0;
        s_axi.wvalid  = 1'b0; s_axi.wdata  = '0; s_axi.wstrb  = '0;
        s_axi.arvalid = 1'b0; s_axi.araddr = '0; s_axi.arprot = '0;
        s_axi.bready  = 1'b1; s_axi.rready = 1'b1;
    endtask

    task automatic test_reset();
        idle_bus();
        rst = 1'b1;
        tick();
        tick();
        tests++;
        if ({s_axi.awready, s_axi.wready, s_axi.arready} !== 3'b000) begin
            fails++; $display("FAIL reset_ready: got %b expected 000", {s_axi.awready, s_axi.wready, s_axi.arready});
        end
        rst = 1'b0;
        #1;
        tests++;
        if ({s_axi.bvalid, s_axi.rvalid, s_axi.bresp, s_axi.rresp} !== 6'b0) begin
            fails++; $display("FAIL reset_resp: got %b expected 0", {s_axi.bvalid, s_axi.rvalid, s_axi.bresp, s_axi.rresp});
        end
        tests++;
        if (regs_o !== '0 || wr_pulse_o !== '0 || s_axi.rdata !== 32'h0) begin
            fails++; $display("FAIL reset_regs: regs/pulse/rdata not zero (pulse=%h rdata=%h)", wr_pulse_o, s_axi.rdata);
        end
        tests++;
        if ({s_axi.awready, s_axi.wready, s_axi.arready} !== 3'b111) begin
            fails++; $display("FAIL post_reset_ready: got %b expected 111", {s_axi.awready, s_axi.wready, s_axi.arready});
        end
        exp_regs = '0;
    endtask

    task automatic test_write_read_basic();
        s_axi.awvalid = 1'b1; s_axi.awaddr = 32'h4;
        s_axi.wvalid = 1'b1; s_axi.wdata = 32'hDEADBEEF; s_axi.wstrb = 4'hF;
        tick();
        s_axi.awvalid = 1'b0; s_axi.wvalid = 1'b0;
        exp_regs[63:32] = 32'hDEADBEEF;
        tests++;
        if (s_axi.bvalid !== 1'b1 || s_axi.bresp !== 2'b00) begin
            fails++; $display("FAIL basic_b: bvalid=%b bresp=%b expected 1/00", s_axi.bvalid, s_axi.bresp);
        end
        tests++;
        if (regs_o !== exp_regs) begin
            fails++; $display("FAIL basic_reg1: got %h expected DEADBEEF", regs_o[63:32]);
        end
        tests++;
        if (wr_pulse_o !== 16'h0002) begin
            fails++; $display("FAIL basic_pulse: got %h expected 0002", wr_pulse_o);
        end
        tick();
        tests++;
        if (s_axi.bvalid !== 1'b0 || wr_pulse_o !== 16'h0000) begin
            fails++; $display("FAIL basic_b_clear: bvalid=%b pulse=%h expected 0/0000", s_axi.bvalid, wr_pulse_o);
        end
        s_axi.arvalid = 1'b1; s_axi.araddr = 32'h4;
        tick();
        s_axi.arvalid = 1'b0;
        tests++;
        if (s_axi.rvalid !== 1'b1 || s_axi.rdata !== 32'hDEADBEEF || s_axi.rresp !== 2'b00) begin
            fails++; $display("FAIL basic_read: rvalid=%b rdata=%h rresp=%b expected 1/DEADBEEF/00", s_axi.rvalid, s_axi.rdata, s_axi.rresp);
        end
        tick();
        tests++;
        if (s_axi.rvalid !== 1'b0) begin
            fails++; $display("FAIL basic_r_clear: rvalid=%b expected 0", s_axi.rvalid);
        end
    endtask

    task automatic test_w_before_aw_strobe();
        int bcount;
        s_axi.awvalid = 1'b1; s_axi.awaddr = 32'h8;
        s_axi.wvalid = 1'b1; s_axi.wdata = 32'hAABBCCDD; s_axi.wstrb = 4'hF;
        tick();
        s_axi.awvalid = 1'b0; s_axi.wvalid = 1'b0;
        tick();
        s_axi.wvalid = 1'b1; s_axi.wdata = 32'h11223344; s_axi.wstrb = 4'h5;
        tick();
        s_axi.wvalid = 1'b0;
        tests++;
        if (s_axi.wready !== 1'b0 || s_axi.awready !== 1'b1) begin
            fails++; $display("FAIL w_held_ready: wready=%b awready=%b expected 0/1", s_axi.wready, s_axi.awready);
        end
        bcount = 0;
        for (int i = 0; i < 2; i++) begin
            if (s_axi.bvalid) bcount++;
            tick();
        end
        if (s_axi.bvalid) bcount++;
        s_axi.awvalid = 1'b1; s_axi.awaddr = 32'h8;
        tick();
        s_axi.awvalid = 1'b0;
        exp_regs[95:64] = 32'hAA22CC44;
        tests++;
        if (bcount !== 0 || s_axi.bvalid !== 1'b1 || s_axi.bresp !== 2'b00) begin
            fails++; $display("FAIL w_first_b: early=%0d bvalid=%b expected 0/1", bcount, s_axi.bvalid);
        end
        tests++;
        if (regs_o !== exp_regs || wr_pulse_o !== 16'h0004) begin
            fails++; $display("FAIL strobe_reg2: got %h pulse=%h expected AA22CC44/0004", regs_o[95:64], wr_pulse_o);
        end
        bcount = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (s_axi.bvalid) bcount++;
        end
        tests++;
        if (bcount !== 0) begin
            fails++; $display("FAIL single_b: extra bvalid cycles=%0d expected 0", bcount);
        end
    endtask

    task automatic test_out_of_range();
        s_axi.awvalid = 1'b1; s_axi.awaddr = 32'h40;
        s_axi.wvalid = 1'b1; s_axi.wdata = 32'hFFFFFFFF; s_axi.wstrb = 4'hF;
        tick();
        s_axi.awvalid = 1'b0; s_axi.wvalid = 1'b0;
        tests++;
        if (s_axi.bvalid !== 1'b1 || s_axi.bresp !== 2'b10) begin
            fails++; $display("FAIL oor_b: bvalid=%b bresp=%b expected 1/10", s_axi.bvalid, s_axi.bresp);
        end
        tests++;
        if (regs_o !== exp_regs || wr_pulse_o !== 16'h0000) begin
            fails++; $display("FAIL oor_regs: registers changed or pulse=%h expected 0000", wr_pulse_o);
        end
        tick();
        s_axi.arvalid = 1'b1; s_axi.araddr = 32'h40;
        tick();
        s_axi.arvalid = 1'b0;
        tests++;
        if (s_axi.rvalid !== 1'b1 || s_axi.rdata !== 32'h0 || s_axi.rresp !== 2'b10) begin
            fails++; $display("FAIL oor_read: rvalid=%b rdata=%h rresp=%b expected 1/0/10", s_axi.rvalid, s_axi.rdata, s_axi.rresp);
        end
        tick();
    endtask

    task automatic test_backpressure();
        int bad;
        s_axi.bready = 1'b0;
        s_axi.awvalid = 1'b1; s_axi.awaddr = 32'h10;
        s_axi.wvalid = 1'b1; s_axi.wdata = 32'h0000_1111; s_axi.wstrb = 4'hF;
        tick();
        exp_regs[159:128] = 32'h0000_1111;
        s_axi.awaddr = 32'h14; s_axi.wdata = 32'h0000_5555;
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            if (s_axi.awready !== 1'b0 || s_axi.wready !== 1'b0) bad++;
            if (s_axi.bvalid !== 1'b1 || s_axi.bresp !== 2'b00) bad++;
            tick();
        end
        tests++;
        if (bad !== 0) begin
            fails++; $display("FAIL bp_stall: violations=%0d expected 0", bad);
        end
        tests++;
        if (regs_o !== exp_regs) begin
            fails++; $display("FAIL bp_regs: reg4=%h reg5=%h expected 00001111/0", regs_o[159:128], regs_o[191:160]);
        end
        s_axi.bready = 1'b1;
        tick();
        tests++;
        if (s_axi.bvalid !== 1'b0 || s_axi.awready !== 1'b1 || s_axi.wready !== 1'b1) begin
            fails++; $display("FAIL bp_release: bvalid=%b awready=%b wready=%b expected 0/1/1", s_axi.bvalid, s_axi.awready, s_axi.wready);
        end
        tick();
        s_axi.awvalid = 1'b0; s_axi.wvalid = 1'b0;
        exp_regs[191:160] = 32'h0000_5555;
        tests++;
        if (s_axi.bvalid !== 1'b1 || regs_o !== exp_regs || wr_pulse_o !== 16'h0020) begin
            fails++; $display("FAIL bp_second: bvalid=%b reg5=%h pulse=%h expected 1/00005555/0020", s_axi.bvalid, regs_o[191:160], wr_pulse_o);
        end
        tick();
    endtask

    task automatic test_same_cycle_rw();
        s_axi.awvalid = 1'b1; s_axi.awaddr = 32'hC;
        s_axi.wvalid = 1'b1; s_axi.wdata = 32'h1; s_axi.wstrb = 4'hF;
        tick();
        s_axi.awvalid = 1'b0; s_axi.wvalid = 1'b0;
        tick();
        s_axi.awvalid = 1'b1; s_axi.awaddr = 32'hC;
        s_axi.wvalid = 1'b1; s_axi.wdata = 32'h2;
        s_axi.arvalid = 1'b1; s_axi.araddr = 32'hC;
        tick();
        s_axi.awvalid = 1'b0; s_axi.wvalid = 1'b0; s_axi.arvalid = 1'b0;
        exp_regs[127:96] = 32'h2;
        tests++;
        if (s_axi.rvalid !== 1'b1 || s_axi.rdata !== 32'h1) begin
            fails++; $display("FAIL rw_old: rvalid=%b rdata=%h expected 1/00000001", s_axi.rvalid, s_axi.rdata);
        end
        tests++;
        if (regs_o !== exp_regs || s_axi.bvalid !== 1'b1) begin
            fails++; $display("FAIL rw_commit: reg3=%h bvalid=%b expected 00000002/1", regs_o[127:96], s_axi.bvalid);
        end
        tick();
        s_axi.arvalid = 1'b1; s_axi.araddr = 32'hC;
        tick();
        s_axi.arvalid = 1'b0;
        tests++;
        if (s_axi.rvalid !== 1'b1 || s_axi.rdata !== 32'h2) begin
            fails++; $display("FAIL rw_new: rvalid=%b rdata=%h expected 1/00000002", s_axi.rvalid, s_axi.rdata);
        end
        tick();
    endtask

    task automatic test_reset_midflight();
        int bcount;
        s_axi.rready = 1'b0;
        s_axi.arvalid = 1'b1; s_axi.araddr = 32'h4;
        s_axi.awvalid = 1'b1; s_axi.awaddr = 32'h18;
        tick();
        s_axi.arvalid = 1'b0; s_axi.awvalid = 1'b0;
        tests++;
        if (s_axi.rvalid !== 1'b1 || s_axi.bvalid !== 1'b0 || s_axi.awready !== 1'b0) begin
            fails++; $display("FAIL mid_setup: rvalid=%b bvalid=%b awready=%b expected 1/0/0", s_axi.rvalid, s_axi.bvalid, s_axi.awready);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_regs = '0;
        #1;
        tests++;
        if (s_axi.rvalid !== 1'b0 || regs_o !== exp_regs || wr_pulse_o !== '0) begin
            fails++; $display("FAIL mid_reset: rvalid=%b pulse=%h regs nonzero=%b expected 0/0/0", s_axi.rvalid, wr_pulse_o, |regs_o);
        end
        s_axi.rready = 1'b1;
        s_axi.wvalid = 1'b1; s_axi.wdata = 32'hCAFE0000; s_axi.wstrb = 4'hF;
        tick();
        s_axi.wvalid = 1'b0;
        bcount = 0;
        for (int i = 0; i < 6; i++) begin
            if (s_axi.bvalid) bcount++;
            tick();
        end
        tests++;
        if (bcount !== 0 || regs_o !== exp_regs) begin
            fails++; $display("FAIL mid_no_b: bvalid cycles=%0d regs nonzero=%b expected 0/0", bcount, |regs_o);
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst = 1'b1;
        exp_regs = '0;
        idle_bus();
        test_reset();
        test_write_read_basic();
        test_w_before_aw_strobe();
        test_out_of_range();
        test_backpressure();
        test_same_cycle_rw();
        test_reset_midflight();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
